// File: rtl/mul3_pipe.sv
// Two-stage pipelined unsigned multiplier producing a*b and (a*b*c) mod 2^P2_W.
// Stage 1 forms a*b and keeps c; stage 2 multiplies them and flags lost high bits.
module mul3_pipe #(
  parameter int A_W  = 4,
  parameter int B_W  = 4,
  parameter int C_W  = 8,
  parameter int P1_W = 8,
  parameter int P2_W = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [A_W-1:0]  a,
  input  logic [B_W-1:0]  b,
  input  logic [C_W-1:0]  c,
  output logic            out_valid,
  output logic [P1_W-1:0] P1,
  output logic [P2_W-1:0] P2,
  output logic            p2_ovf
);

  localparam int FULL_W = P1_W + C_W;

  logic            s1_valid_q, s1_valid_d;
  logic [P1_W-1:0] s1_ab_q, s1_ab_d;
  logic [C_W-1:0]  s1_c_q, s1_c_d;
  logic            out_valid_q, out_valid_d;
  logic [P1_W-1:0] p1_q, p1_d;
  logic [P2_W-1:0] p2_q, p2_d;
  logic            ovf_q, ovf_d;
  logic [FULL_W-1:0] full;

  // Data registers only load on a valid beat, so idle operands never reach them.
  always_comb begin
    s1_valid_d = in_valid;
    s1_ab_d    = s1_ab_q;
    s1_c_d     = s1_c_q;
    if (in_valid) begin
      s1_ab_d = P1_W'(a) * P1_W'(b);
      s1_c_d  = c;
    end
  end

  assign full = FULL_W'(s1_ab_q) * FULL_W'(s1_c_q);

  always_comb begin
    out_valid_d = s1_valid_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    ovf_d       = ovf_q;
    if (s1_valid_q) begin
      p1_d  = s1_ab_q;
      p2_d  = full[P2_W-1:0];
      ovf_d = |full[FULL_W-1:P2_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_ab_q     <= '0;
      s1_c_q      <= '0;
      out_valid_q <= 1'b0;
      p1_q        <= '0;
      p2_q        <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ab_q     <= s1_ab_d;
      s1_c_q      <= s1_c_d;
      out_valid_q <= out_valid_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign P1        = p1_q;
  assign P2        = p2_q;
  assign p2_ovf    = ovf_q;

endmodule

// File: tb/tb_mul3_pipe.sv
// Testbench for mul3_pipe: directed and random beats checked against an
// arithmetic model that predicts each result one step after the step that fed it.
module tb_mul3_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  a, b;
  logic [7:0]  c;
  logic        out_valid;
  logic [7:0]  P1;
  logic [13:0] P2;
  logic        p2_ovf;

  int total  = 0;
  int passed = 0;

  bit pendV;
  int pendA, pendB, pendC;
  bit expV;
  int expP1, expP2;
  bit expOvf;

  mul3_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c),
    .out_valid(out_valid), .P1(P1), .P2(P2), .p2_ovf(p2_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(expV));
    checkOutput({tag, "_P1"}, 32'(P1), 32'(expP1));
    checkOutput({tag, "_P2"}, 32'(P2), 32'(expP2));
    checkOutput({tag, "_ovf"}, 32'(p2_ovf), 32'(expOvf));
  endtask

  task automatic modelReset();
    pendV = 0; pendA = 0; pendB = 0; pendC = 0;
    expV = 0; expP1 = 0; expP2 = 0; expOvf = 0;
  endtask

  // Called at a falling edge: drive one beat, clock it in, then check the beat before it.
  task automatic applyStimulus(input bit v, input int ia, input int ib, input int ic, input string tag);
    int full;
    in_valid = v;
    a = 4'(ia); b = 4'(ib); c = 8'(ic);
    @(posedge clk);
    @(negedge clk);
    expV = pendV;
    if (pendV) begin
      full   = pendA * pendB * pendC;
      expP1  = pendA * pendB;
      expP2  = full % 16384;
      expOvf = (full >= 16384);
    end
    pendV = v; pendA = ia; pendB = ib; pendC = ic;
    checkAll(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;
    modelReset();
    #1 checkAll("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1, i - 1, i, i, "sweep");
      if (i == 2) checkOutput("sweep1_P1", 32'(P1), 0);
      if (i == 5) begin
        checkOutput("sweep4_P1", 32'(P1), 12);
        checkOutput("sweep4_P2", 32'(P2), 48);
      end
    end
    applyStimulus(0, 9, 9, 9, "sweep_tail");
    checkOutput("sweep15_P1", 32'(P1), 210);
    checkOutput("sweep15_P2", 32'(P2), 3150);
    applyStimulus(0, 1, 2, 3, "idle");

    applyStimulus(1, 15, 15, 255, "ovf_in");
    applyStimulus(0, 0, 0, 0, "ovf_out");
    checkOutput("ovf_P1", 32'(P1), 225);
    checkOutput("ovf_P2", 32'(P2), 8223);
    checkOutput("ovf_flag", 32'(p2_ovf), 1);

    applyStimulus(1, 8, 8, 255, "edge_in");
    applyStimulus(1, 8, 8, 0, "edge_out");
    checkOutput("edge_P2", 32'(P2), 16320);
    checkOutput("edge_ovf", 32'(p2_ovf), 0);
    applyStimulus(0, 5, 5, 5, "zero_out");
    checkOutput("zero_P1", 32'(P1), 64);
    checkOutput("zero_P2", 32'(P2), 0);

    applyStimulus(1, 3, 5, 2, "bub_a");
    applyStimulus(0, 7, 7, 7, "bub_1");
    checkOutput("bub_P2", 32'(P2), 30);
    applyStimulus(0, 6, 6, 6, "bub_2");
    applyStimulus(1, 2, 2, 2, "bub_b");
    checkOutput("bub_hold_P1", 32'(P1), 15);
    applyStimulus(0, 1, 1, 1, "bub_3");
    checkOutput("bub_new_P2", 32'(P2), 8);

    #2 rst_n = 1'b0;
    modelReset();
    #1 checkAll("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1, 7, 9, 100, "mid_a");
    in_valid = 1'b1; a = 4'd5; b = 4'd6; c = 8'd7;
    #1 rst_n = 1'b0;
    modelReset();
    #1 checkAll("mid_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, "mid_drain1");
    applyStimulus(0, 0, 0, 0, "mid_drain2");
    applyStimulus(1, 3, 3, 3, "mid_new");
    applyStimulus(0, 0, 0, 0, "mid_new_out");
    checkOutput("mid_new_P2", 32'(P2), 27);

    for (int n = 0; n < 60; n++)
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), "rand");
    applyStimulus(0, 0, 0, 0, "rand_tail");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul3_pipe.md
Name: mul3_pipe

Overview:
- Pipelined three-operand unsigned multiplier.
- Computes the partial product P1 = a*b and the full product P2 = a*b*c.
- Registered valid-tagged outputs, for use as a datapath arithmetic leaf block.
- The single-cycle combinational form is replaced by a 2-stage registered pipeline with overflow reporting.

Parameters:
A_W  4   width of operand a
B_W  4   width of operand b
C_W  8   width of operand c
P1_W 8   width of P1 (A_W+B_W; a*b never overflows)
P2_W 14  width of P2; full product is truncated to this width

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      a, b, c are valid this cycle
a          input   A_W    unsigned operand
b          input   B_W    unsigned operand
c          input   C_W    unsigned operand
out_valid  output  1      P1/P2/p2_ovf hold a new result this cycle
P1         output  P1_W   a*b, unsigned
P2         output  P2_W   (a*b*c) mod 2^P2_W, unsigned
p2_ovf     output  1      1 when the full a*b*c does not fit in P2_W bits

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state is cleared immediately on rst_n=0, independent of clk.
- Reset values: out_valid=0, P1=0, P2=0, p2_ovf=0. The internal stage-1 registers (valid, product, c copy) are also 0.
- Stage 1, at posedge clk:
  - s1_valid <= in_valid.
  - If in_valid=1: s1_ab <= a*b (P1_W bits) and s1_c <= c.
  - If in_valid=0: s1_ab and s1_c hold.
- Stage 2, at posedge clk:
  - out_valid <= s1_valid.
  - If s1_valid=1:
    - P1 <= s1_ab.
    - full = s1_ab*s1_c, computed at P1_W+C_W = 16 bits.
    - P2 <= full[P2_W-1:0].
    - p2_ovf <= |full[P1_W+C_W-1:P2_W].
  - If s1_valid=0: P1, P2 and p2_ovf hold their last values.
- Latency: exactly 2 cycles from the in_valid sample edge to out_valid=1 with the matching result.
- Throughput: 1 result per cycle. No backpressure, no stall input; the pipeline always advances.
- out_valid is a 1-cycle pulse per accepted input. Back-to-back inputs give a contiguous out_valid run, in order.
- Bubbles (in_valid=0) propagate as out_valid=0 and leave the output data unchanged.
- Arithmetic rules:
  - All unsigned; no sign extension.
  - P1 is exact.
  - P2 wraps modulo 2^14.
  - Any operand equal to 0 gives P2=0 and p2_ovf=0.
- Reset mid-operation: in-flight results are discarded; out_valid stays 0 until 2 cycles after the first in_valid following rst_n deassertion.
- Inputs are ignored (not captured) while rst_n=0.
- No X propagation from a/b/c when in_valid=0: the data registers do not load.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> out_valid=0, P1=0, P2=0, p2_ovf=0 immediately, before the next clk edge.
- Sweep i=1..15 with a=i-1, b=i, c=i, one per cycle with in_valid=1 -> outputs 2 cycles later, for example:
  - i=1: P1=0, P2=0.
  - i=4: P1=12, P2=48.
  - i=15: P1=210, P2=3150.
  - p2_ovf=0 throughout; out_valid high for 15 consecutive cycles.
- Overflow: a=15, b=15, c=255 -> P1=225, P2=8223 (57375 mod 16384), p2_ovf=1.
- Boundary without overflow: a=8, b=8, c=255 (16320) -> P2=16320, p2_ovf=0. With c=0 -> P1=64, P2=0, p2_ovf=0.
- Bubbles: a=3,b=5,c=2, then 2 idle cycles, then a=2,b=2,c=2 -> out_valid pattern 1,0,0,1. Outputs are P1=15, P2=30, held through the idle cycles, then P1=4, P2=8.
- Mid-stream reset: issue 2 valid inputs, pulse rst_n low for 1 cycle before they emerge -> no out_valid for them. Outputs stay 0 until the next post-reset input appears 2 cycles after its capture.
